ps2_mouse_init_sequencer: RTL and testbench
===========================================

# ps2_mouse_init_sequencer

Host-side controller that configures a PS/2 mouse and then frames its stream packets. It drives a byte-level PS/2 host transceiver through a command/response handshake: reset, BAT check, sample rate, resolution, then stream enable. It handles acknowledgements, resend requests, timeouts and retries. Once streaming, it forwards only packet-aligned bytes to the PS/2-to-serial-mouse converter.

## Interface
- `CLKFREQ`, 50_000_000: clock frequency in Hz; sets the 1 ms tick prescaler (`CLKFREQ/1000` cycles).
- `SAMPLE_RATE`, 8'd100: argument sent after command F3.
- `RESOLUTION`, 8'h02: argument sent after command E8.
- `RETRIES`, 3: maximum resends per byte before failure.
- `RESP_TIMEOUT_MS`, 25: response timeout for ACKs and IDs.
- `BAT_TIMEOUT_MS`, 750: timeout for the AA byte after reset.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; aborts any activity and restarts the sequence.
- `tx_data` out 8: command byte to the transceiver.
- `tx_valid` out 1: command byte pending.
- `tx_ready` in 1: transceiver accepts the byte in the cycle where `tx_valid && tx_ready`.
- `rx_data` in 8: byte received from the mouse.
- `rx_valid` in 1: one-cycle strobe qualifying `rx_data`.
- `stream_data` out 8: aligned packet byte.
- `stream_valid` out 1: one-cycle strobe.
- `stream_first` out 1: high with `stream_valid` on packet byte 0.
- `mouse_ready` out 1: high while in STREAM.
- `wheel` out 1: IntelliMouse mode detected (4-byte packets).
- `error` out 1: high while in FAIL.

## Operation
- States: PWRUP, SEND, WAIT_ACK, WAIT_BAT, WAIT_ID, STREAM, FAIL.
- PWRUP: waits 1 ms after reset release or `start`, then enters SEND at step 0.
- Step list (byte, expected reply):
  - FF → FA, then AA, then 00.
  - [wheel steps, see Configuration]
  - F3 → FA; SAMPLE_RATE → FA.
  - E8 → FA; RESOLUTION → FA.
  - F4 → FA; then STREAM.
- SEND: drives `tx_data` and `tx_valid=1`, holding both stable until `tx_ready`. Then goes to WAIT_ACK, loads the timeout and clears the ms counter.
- WAIT_ACK:
  - FA: advance. The next state is WAIT_BAT after FF, otherwise SEND of the next step.
  - FE (resend): re-SEND the same byte; retry count +1.
  - FC or any other byte: restart the step list at FF; retry count +1.
  - Timeout: re-SEND the same byte; retry count +1.
- WAIT_BAT: AA → WAIT_ID. Any other byte or timeout → restart at FF; retry +1.
- WAIT_ID: 00 → next step. Other byte or timeout → restart at FF; retry +1.
- Retry counter: reset on every accepted FA/AA/00. When it would exceed `RETRIES` → FAIL.
- FAIL: `error=1`, all `rx` ignored; exits only on `start` or reset.
- STREAM packet framing:
  - Byte index wraps at 3, or at 4 when `wheel=1`.
  - At index 0, a byte with bit3=0 is dropped and the index stays 0 (resync).
  - Every accepted byte is forwarded: `stream_valid=1` next cycle, `stream_first=1` at index 0.
- `rx_valid` in SEND is ignored.
- `start` takes priority over every event in the same cycle: `tx_valid` drops next cycle, and packet index, retry count and `wheel` clear.

## Timing
- Reset values: `tx_data` 00, `tx_valid` 0, `stream_data` 00, `stream_valid` 0, `stream_first` 0, `mouse_ready` 0, `wheel` 0, `error` 0.
- Reply-to-action latency: 1 cycle from `rx_valid` to a registered state change. `tx_valid` rises 1 cycle after entering SEND.
- Stream latency: `rx_valid` → `stream_valid` is 1 cycle.
- Timeouts are counted in whole ms ticks and are accurate to −1/+0 ms. A reply and a timeout in the same cycle: the reply wins.
- `mouse_ready` rises in the cycle STREAM is entered and falls on `start`.

## Configuration
- `PS2SEQ_WHEEL_EN` defined:
  - After the FF/AA/00 step, sends F3 C8, F3 64, F3 50, then F2. Each byte expects FA; after F2's FA, WAIT_ID expects one ID byte.
  - ID 03 → `wheel=1`; any other ID → `wheel=0`. Both continue normally.
  - Packets are 4 bytes when `wheel=1`.
- Not defined: wheel steps are absent, `wheel` is tied 0, and packets are always 3 bytes.

## Test plan
- Nominal: the model ACKs every byte and returns AA, 00 after FF. Expected `tx` bytes are FF F3 64 E8 02 F4; `mouse_ready` rises 1 cycle after the final FA.
- Resend: model answers F3 with FE once. Expect F3 re-sent, then the sequence completes; `error` stays 0.
- Timeout: model stays silent after E8 with `RETRIES`=3. Expect 4 E8 transmissions spaced about 25 ms apart, then `error=1`. A `start` pulse afterwards re-sends FF after 1 ms.
- Framing: in STREAM, inject 00, 08, 05, FD, 09. Expect 00 dropped; then 08 (first), 05, FD, then 09 (first).
- Wheel build: model returns ID 03 to F2. Expect `wheel=1`; the stream 08 01 02 FF gives `stream_first` only on 08, and the next 09 is flagged first.
- Abort: `start` asserted while `tx_valid=1` and `tx_ready=0`. Expect `tx_valid=0` next cycle and `mouse_ready=0`.

Source files
------------

// File: rtl/ps2_mouse_init_sequencer_if.sv
// Byte-level bus between the PS/2 mouse init sequencer, the PS/2 host
// transceiver (tx/rx bytes) and the downstream serial-mouse converter
// (aligned stream bytes).
// master: the sequencer. slave: the transceiver / stream consumer side.
interface ps2_mouse_init_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] stream_data;
    logic       stream_valid;
    logic       stream_first;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        output stream_data,
        output stream_valid,
        output stream_first
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        input  stream_data,
        input  stream_valid,
        input  stream_first
    );
endinterface

// File: rtl/ps2_mouse_init_sequencer.sv
// PS/2 mouse init sequencer: resets the mouse, checks BAT (AA) and ID (00),
// programs sample rate and resolution, enables streaming, then frames the
// stream into 3-byte (or 4-byte IntelliMouse) packets.
// Optional macro PS2SEQ_WHEEL_EN: adds the F3 C8 / F3 64 / F3 50 / F2 knock
// sequence and detects wheel mode from the returned ID (03).
module ps2_mouse_init_sequencer #(
    parameter int         CLKFREQ         = 50_000_000,
    parameter logic [7:0] SAMPLE_RATE     = 8'd100,
    parameter logic [7:0] RESOLUTION      = 8'h02,
    parameter int         RETRIES         = 3,
    parameter int         RESP_TIMEOUT_MS = 25,
    parameter int         BAT_TIMEOUT_MS  = 750
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    ps2_mouse_init_sequencer_if.master       bus,
    output logic                             mouse_ready,
    output logic                             wheel,
    output logic                             error
);

    localparam int          TICK_CYCLES = (CLKFREQ / 1000 < 1) ? 1 : CLKFREQ / 1000;
    localparam logic [31:0] TICK_LAST   = 32'(TICK_CYCLES - 1);
    localparam logic [7:0]  RETRY_MAX   = 8'(RETRIES);
    localparam logic [15:0] RESP_LIMIT  = 16'(RESP_TIMEOUT_MS);
    localparam logic [15:0] BAT_LIMIT   = 16'(BAT_TIMEOUT_MS);

`ifdef PS2SEQ_WHEEL_EN
    localparam logic [3:0] ID_STEP   = 4'd7;
    localparam logic [3:0] LAST_STEP = 4'd12;
`else
    localparam logic [3:0] LAST_STEP = 4'd5;
`endif

    typedef enum logic [2:0] {
        S_PWRUP,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_BAT,
        S_WAIT_ID,
        S_STREAM,
        S_FAIL
    } state_t;

    state_t      state, state_next;
    logic [3:0]  step, step_next;
    logic [7:0]  retry, retry_next;
    logic        tx_valid_q, tx_valid_next;
    logic [7:0]  tx_data_q, tx_data_next;
    logic [31:0] presc;
    logic [15:0] ms_count;
    logic [15:0] limit;
    logic        ms_tick;
    logic        timeout;
    logic        clear_timer;
    logic        bump;
    state_t      bump_state;
    logic [3:0]  bump_step;
    logic [1:0]  pkt_idx;
    logic [1:0]  pkt_last;
    logic [7:0]  stream_data_q;
    logic        stream_valid_q;
    logic        stream_first_q;

`ifdef PS2SEQ_WHEEL_EN
    logic        wheel_q, wheel_next;
`endif

    // Command byte sent at each step of the configuration list.
    function automatic logic [7:0] step_byte(input logic [3:0] s);
        logic [7:0] b;
        case (s)
`ifdef PS2SEQ_WHEEL_EN
            4'd0:    b = 8'hFF;
            4'd1:    b = 8'hF3;
            4'd2:    b = 8'hC8;
            4'd3:    b = 8'hF3;
            4'd4:    b = 8'h64;
            4'd5:    b = 8'hF3;
            4'd6:    b = 8'h50;
            4'd7:    b = 8'hF2;
            4'd8:    b = 8'hF3;
            4'd9:    b = SAMPLE_RATE;
            4'd10:   b = 8'hE8;
            4'd11:   b = RESOLUTION;
            4'd12:   b = 8'hF4;
`else
            4'd0:    b = 8'hFF;
            4'd1:    b = 8'hF3;
            4'd2:    b = SAMPLE_RATE;
            4'd3:    b = 8'hE8;
            4'd4:    b = RESOLUTION;
            4'd5:    b = 8'hF4;
`endif
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    // Timeout length for the state being timed: 1 ms power-up wait, long BAT wait, short reply wait.
    always_comb begin
        limit = RESP_LIMIT;
        case (state)
            S_PWRUP:    limit = 16'd1;
            S_WAIT_BAT: limit = BAT_LIMIT;
            default:    limit = RESP_LIMIT;
        endcase
    end

    assign ms_tick     = (presc == TICK_LAST);
    assign timeout     = ms_tick && (ms_count == limit - 16'd1);
    assign clear_timer = start || (state_next != state);

    // Millisecond prescaler and ms counter, restarted whenever the state changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc    <= '0;
            ms_count <= '0;
        end else if (clear_timer) begin
            presc    <= '0;
            ms_count <= '0;
        end else if (ms_tick) begin
            presc    <= '0;
            ms_count <= ms_count + 16'd1;
        end else begin
            presc    <= presc + 32'd1;
        end
    end

    // Next-state logic: step sequencing, reply handling, retries; start overrides everything.
    always_comb begin
        state_next    = state;
        step_next     = step;
        retry_next    = retry;
        tx_valid_next = 1'b0;
        tx_data_next  = tx_data_q;
        bump          = 1'b0;
        bump_state    = S_SEND;
        bump_step     = step;
`ifdef PS2SEQ_WHEEL_EN
        wheel_next    = wheel_q;
`endif

        case (state)
            S_PWRUP: begin
                if (timeout) begin
                    state_next = S_SEND;
                    step_next  = 4'd0;
                end
            end

            S_SEND: begin
                tx_data_next  = step_byte(step);
                tx_valid_next = !(tx_valid_q && bus.tx_ready);
                if (tx_valid_q && bus.tx_ready) begin
                    state_next = S_WAIT_ACK;
                end
            end

            S_WAIT_ACK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == 8'hFA) begin
                        retry_next = 8'd0;
                        if (step == 4'd0) begin
                            state_next = S_WAIT_BAT;
`ifdef PS2SEQ_WHEEL_EN
                        end else if (step == ID_STEP) begin
                            state_next = S_WAIT_ID;
`endif
                        end else if (step == LAST_STEP) begin
                            state_next = S_STREAM;
                        end else begin
                            state_next = S_SEND;
                            step_next  = step + 4'd1;
                        end
                    end else if (bus.rx_data == 8'hFE) begin
                        bump      = 1'b1;
                        bump_step = step;
                    end else begin
                        bump      = 1'b1;
                        bump_step = 4'd0;
                    end
                end else if (timeout) begin
                    bump      = 1'b1;
                    bump_step = step;
                end
            end

            S_WAIT_BAT: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == 8'hAA) begin
                        retry_next = 8'd0;
                        state_next = S_WAIT_ID;
                    end else begin
                        bump      = 1'b1;
                        bump_step = 4'd0;
                    end
                end else if (timeout) begin
                    bump      = 1'b1;
                    bump_step = 4'd0;
                end
            end

            S_WAIT_ID: begin
                if (bus.rx_valid) begin
`ifdef PS2SEQ_WHEEL_EN
                    if (step == ID_STEP) begin
                        wheel_next = (bus.rx_data == 8'h03);
                        retry_next = 8'd0;
                        state_next = S_SEND;
                        step_next  = step + 4'd1;
                    end else
`endif
                    if (bus.rx_data == 8'h00) begin
                        retry_next = 8'd0;
                        state_next = S_SEND;
                        step_next  = step + 4'd1;
                    end else begin
                        bump      = 1'b1;
                        bump_step = 4'd0;
                    end
                end else if (timeout) begin
                    bump      = 1'b1;
                    bump_step = 4'd0;
                end
            end

            S_STREAM: begin
                state_next = S_STREAM;
            end

            S_FAIL: begin
                state_next = S_FAIL;
            end

            default: begin
                state_next = S_PWRUP;
                step_next  = 4'd0;
            end
        endcase

        if (bump) begin
            if (retry == RETRY_MAX) begin
                state_next = S_FAIL;
            end else begin
                retry_next = retry + 8'd1;
                state_next = bump_state;
                step_next  = bump_step;
            end
        end

        if (start) begin
            state_next    = S_PWRUP;
            step_next     = 4'd0;
            retry_next    = 8'd0;
            tx_valid_next = 1'b0;
`ifdef PS2SEQ_WHEEL_EN
            wheel_next    = 1'b0;
`endif
        end
    end

    // Sequencer state register and registered transmit outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_PWRUP;
            step       <= 4'd0;
            retry      <= 8'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state      <= state_next;
            step       <= step_next;
            retry      <= retry_next;
            tx_valid_q <= tx_valid_next;
            tx_data_q  <= tx_data_next;
        end
    end

`ifdef PS2SEQ_WHEEL_EN
    // Wheel-mode flag captured from the ID returned after the knock sequence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wheel_q <= 1'b0;
        end else begin
            wheel_q <= wheel_next;
        end
    end

    assign wheel = wheel_q;
`else
    assign wheel = 1'b0;
`endif

    assign pkt_last = wheel ? 2'd3 : 2'd2;

    // Packet framing: drop misaligned first bytes (bit3 clear) and tag byte 0 of each packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_idx        <= 2'd0;
            stream_data_q  <= 8'h00;
            stream_valid_q <= 1'b0;
            stream_first_q <= 1'b0;
        end else begin
            stream_valid_q <= 1'b0;
            stream_first_q <= 1'b0;
            if (start) begin
                pkt_idx <= 2'd0;
            end else if (state == S_STREAM && bus.rx_valid) begin
                if (pkt_idx != 2'd0 || bus.rx_data[3]) begin
                    stream_data_q  <= bus.rx_data;
                    stream_valid_q <= 1'b1;
                    stream_first_q <= (pkt_idx == 2'd0);
                    pkt_idx        <= (pkt_idx == pkt_last) ? 2'd0 : pkt_idx + 2'd1;
                end
            end
        end
    end

    assign bus.tx_data      = tx_data_q;
    assign bus.tx_valid     = tx_valid_q;
    assign bus.stream_data  = stream_data_q;
    assign bus.stream_valid = stream_valid_q;
    assign bus.stream_first = stream_first_q;
    assign mouse_ready      = (state == S_STREAM);
    assign error            = (state == S_FAIL);

endmodule

// File: tb/tb_ps2_mouse_init_sequencer.sv
// Testbench for ps2_mouse_init_sequencer: a mouse model answers the command
// list (nominal, resend, silent timeout, abort), and random stream bytes are
// framed by a packet model kept here. Wheel scenarios follow PS2SEQ_WHEEL_EN.
module tb_ps2_mouse_init_sequencer;

    localparam int CLKFREQ = 10_000;
`ifdef PS2SEQ_WHEEL_EN
    localparam bit WHEEL_BUILD = 1'b1;
`else
    localparam bit WHEEL_BUILD = 1'b0;
`endif
    localparam int PKT_LEN = WHEEL_BUILD ? 4 : 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic mouse_ready;
    logic wheel;
    logic error;

    ps2_mouse_init_sequencer_if bus ();

    ps2_mouse_init_sequencer #(
        .CLKFREQ(CLKFREQ),
        .SAMPLE_RATE(8'd100),
        .RESOLUTION(8'h02),
        .RETRIES(3),
        .RESP_TIMEOUT_MS(25),
        .BAT_TIMEOUT_MS(750)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .bus(bus),
        .mouse_ready(mouse_ready),
        .wheel(wheel),
        .error(error)
    );

    always #5 clk = ~clk;

    int unsigned cycles = 0;
    always @(posedge clk) cycles <= cycles + 1;

    int checks = 0;
    int passed = 0;
    logic [7:0] exp_cmds[$];
    int model_idx = 0;
    int unsigned accept_cycle = 0;

    // Backstop in case a bounded wait is somehow bypassed.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic idle(input int max_cycles);
        repeat ($urandom_range(0, max_cycles)) @(negedge clk);
    endtask

    // Present one received byte for a single cycle; returns after the DUT edge.
    task automatic applyStimulus(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // Wait for a command byte, hold off tx_ready randomly, check it and accept it.
    task automatic waitTx(input logic [7:0] expected, input int budget, input string tag);
        int n = 0;
        while (bus.tx_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_valid"}, {31'd0, bus.tx_valid}, 32'd1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        checkOutput(tag, {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, expected});
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        accept_cycle = cycles;
        checkOutput({tag, "_drop"}, {31'd0, bus.tx_valid}, 32'd0);
    endtask

    // Mouse model walking the expected command list.
    task automatic runSequence(input int resend_cmd, input int silent_cmd, input logic [7:0] id_reply);
        bit resent = 1'b0;
        foreach (exp_cmds[i]) begin
            waitTx(exp_cmds[i], 400, "cmd");
            if (int'(exp_cmds[i]) == silent_cmd) return;
            if (int'(exp_cmds[i]) == resend_cmd && !resent) begin
                resent = 1'b1;
                idle(4);
                applyStimulus(8'hFE);
                waitTx(exp_cmds[i], 40, "resend");
            end
            idle(4);
            applyStimulus(8'hFA);
            if (exp_cmds[i] == 8'hFF) begin
                idle(6);
                applyStimulus(8'hAA);
                idle(6);
                applyStimulus(8'h00);
            end
            if (exp_cmds[i] == 8'hF2) begin
                idle(4);
                applyStimulus(id_reply);
            end
        end
    endtask

    // Packet model: byte 0 needs bit3 set, index wraps at the packet length.
    task automatic streamByte(input logic [7:0] b);
        bit keep;
        keep = !(model_idx == 0 && b[3] == 1'b0);
        applyStimulus(b);
        checkOutput("stream_valid", {31'd0, bus.stream_valid}, {31'd0, keep});
        if (keep) begin
            checkOutput("stream_data", {24'd0, bus.stream_data}, {24'd0, b});
            checkOutput("stream_first", {31'd0, bus.stream_first}, {31'd0, model_idx == 0});
            model_idx = (model_idx + 1) % PKT_LEN;
        end
        idle(2);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int unsigned t0;
        int unsigned prev;
        int n;
        logic [7:0] directed[$];

        exp_cmds.push_back(8'hFF);
`ifdef PS2SEQ_WHEEL_EN
        exp_cmds.push_back(8'hF3); exp_cmds.push_back(8'hC8);
        exp_cmds.push_back(8'hF3); exp_cmds.push_back(8'h64);
        exp_cmds.push_back(8'hF3); exp_cmds.push_back(8'h50);
        exp_cmds.push_back(8'hF2);
`endif
        exp_cmds.push_back(8'hF3); exp_cmds.push_back(8'd100);
        exp_cmds.push_back(8'hE8); exp_cmds.push_back(8'h02);
        exp_cmds.push_back(8'hF4);

        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("rst_tx_data", {24'd0, bus.tx_data}, 32'h00);
        checkOutput("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        checkOutput("rst_stream_data", {24'd0, bus.stream_data}, 32'h00);
        checkOutput("rst_stream_valid", {31'd0, bus.stream_valid}, 32'd0);
        checkOutput("rst_stream_first", {31'd0, bus.stream_first}, 32'd0);
        checkOutput("rst_mouse_ready", {31'd0, mouse_ready}, 32'd0);
        checkOutput("rst_wheel", {31'd0, wheel}, 32'd0);
        checkOutput("rst_error", {31'd0, error}, 32'd0);

        // Power-up: 1 ms (10 cycles) before FF appears.
        reset_n = 1'b1;
        t0 = cycles;
        repeat (5) @(negedge clk);
        checkOutput("pwrup_quiet", {31'd0, bus.tx_valid}, 32'd0);
        n = 0;
        while (bus.tx_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pwrup_delay", {31'd0, (cycles - t0) >= 9 && (cycles - t0) <= 13}, 32'd1);

        // Nominal configuration.
        $display("[TB] nominal sequence");
        runSequence(-1, -1, 8'h03);
        checkOutput("nom_mouse_ready", {31'd0, mouse_ready}, 32'd1);
        checkOutput("nom_error", {31'd0, error}, 32'd0);
        checkOutput("nom_wheel", {31'd0, wheel}, {31'd0, WHEEL_BUILD});

        // Framing: directed bytes then random bytes.
        $display("[TB] stream framing");
        model_idx = 0;
        if (WHEEL_BUILD) directed = '{8'h00, 8'h08, 8'h01, 8'h02, 8'hFF, 8'h09};
        else             directed = '{8'h00, 8'h08, 8'h05, 8'hFD, 8'h09};
        foreach (directed[i]) streamByte(directed[i]);
        for (int i = 0; i < 24; i++) streamByte(8'($urandom));

        // Abort from STREAM, then abort while a byte is pending.
        $display("[TB] abort");
        pulseStart();
        checkOutput("abort_ready_low", {31'd0, mouse_ready}, 32'd0);
        checkOutput("abort_error_low", {31'd0, error}, 32'd0);
        n = 0;
        while (bus.tx_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_pending_ff", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, 8'hFF});
        repeat (2) @(negedge clk);
        pulseStart();
        checkOutput("abort_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        checkOutput("abort_mouse_ready", {31'd0, mouse_ready}, 32'd0);

        // Resend: F3 answered once with FE.
        $display("[TB] resend");
        runSequence(32'hF3, -1, 8'h00);
        checkOutput("resend_ready", {31'd0, mouse_ready}, 32'd1);
        checkOutput("resend_error", {31'd0, error}, 32'd0);
        checkOutput("resend_wheel", {31'd0, wheel}, 32'd0);

        // Timeout: silent after E8, four transmissions, then failure.
        $display("[TB] timeout");
        pulseStart();
        runSequence(-1, 32'hE8, 8'h03);
        for (int k = 1; k <= 3; k++) begin
            prev = accept_cycle;
            waitTx(8'hE8, 400, "retx_e8");
            checkOutput("retx_spacing", {31'd0, (accept_cycle - prev) >= 240 && (accept_cycle - prev) <= 262}, 32'd1);
            checkOutput("retx_error_low", {31'd0, error}, 32'd0);
        end
        n = 0;
        while (error !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fail_error", {31'd0, error}, 32'd1);
        checkOutput("fail_wait", {31'd0, n >= 240 && n <= 262}, 32'd1);
        checkOutput("fail_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        applyStimulus(8'hFA);
        repeat (3) @(negedge clk);
        checkOutput("fail_sticky", {31'd0, error}, 32'd1);
        checkOutput("fail_not_ready", {31'd0, mouse_ready}, 32'd0);

        // Restart from failure.
        t0 = cycles;
        pulseStart();
        checkOutput("restart_error", {31'd0, error}, 32'd0);
        n = 0;
        while (bus.tx_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("restart_delay", {31'd0, (cycles - t0) >= 9 && (cycles - t0) <= 13}, 32'd1);
        waitTx(8'hFF, 10, "restart_ff");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
